// File: rtl/dbg_uart_tx_pkg.sv
// Shared definitions for the debug telemetry UART transmitter.
package dbg_uart_tx_pkg;

  // Transmitter FSM encoding.
  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StStart = 2'b01,
    StData  = 2'b10,
    StStop  = 2'b11
  } tx_state_e;

  // 50 MHz clock divided down to 19200 baud.
  localparam int unsigned BAUD_DIV_19200 = 2604;

endpackage

// File: rtl/dbg_uart_tx_fifo.sv
// Synchronous byte FIFO with registered full/empty and a sticky overflow flag.
module dbg_fifo #(
  parameter int unsigned Depth = 8,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [7:0]      wdata_i,
  input  logic            clr_ovf_i,
  output logic [7:0]      rdata_o,
  output logic            full_o,
  output logic            empty_o,
  output logic            ovf_o,
  output logic [CntW-1:0] count_o
);

  logic [7:0]      mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            full_q, empty_q;
  logic            ovf_q, ovf_d;
  logic            do_push, do_pop;

  // Flags are pre-edge register values, so a push while full is dropped even if a pop
  // frees a slot on the same edge.
  assign do_push = push_i & ~full_q;
  assign do_pop  = pop_i & ~empty_q;

  // Occupancy and overflow next-state; a dropped push beats clr_ovf.
  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q;
    if (push_i && full_q) begin
      ovf_d = 1'b1;
    end else if (clr_ovf_i) begin
      ovf_d = 1'b0;
    end
  end

  // Pointer, count and flag registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CntW'(Depth));
      empty_q <= (count_d == '0);
      ovf_q   <= ovf_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign ovf_o   = ovf_q;
  assign count_o = count_q;

endmodule

// File: rtl/dbg_uart_tx.sv
// Debug telemetry transmitter: buffers bytes and sends them as back-to-back 8N1 frames.
module dbg_uart_tx
  import dbg_uart_tx_pkg::*;
#(
  parameter int unsigned BAUD_DIV   = BAUD_DIV_19200,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] dbg_data,
  input  logic       dbg_tx,
  input  logic       clr_ovf,
  output logic       TX,
  output logic       dbg_done,
  output logic       tx_busy,
  output logic       full,
  output logic       empty,
  output logic       ovf
);

  localparam int unsigned CntW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] BaudLast    = 16'(BAUD_DIV - 1);
  localparam logic [15:0] BaudPreLast = 16'(BAUD_DIV - 2);

  tx_state_e       state_q, state_d;
  logic [15:0]     baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic            pop;
  logic [7:0]      fifo_rdata;
  logic [CntW-1:0] fifo_count;
  logic            have_byte;
  logic            baud_end;

  dbg_fifo #(
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_i    (clk),
    .rst_i    (rst),
    .push_i   (dbg_tx),
    .pop_i    (pop),
    .wdata_i  (dbg_data),
    .clr_ovf_i(clr_ovf),
    .rdata_o  (fifo_rdata),
    .full_o   (full),
    .empty_o  (empty),
    .ovf_o    (ovf),
    .count_o  (fifo_count)
  );

  assign have_byte = (fifo_count != '0);
  assign baud_end  = (baud_q == BaudLast);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Next state, baud/bit counters and shifter.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + 16'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      StIdle: begin
        baud_d = '0;
        if (have_byte) begin
          state_d = StStart;
          bit_d   = '0;
          shift_d = fifo_rdata;
        end
      end
      StStart: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = StData;
        end
      end
      StData: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end
      end
      StStop: begin
        if (baud_end) begin
          baud_d = '0;
          bit_d  = '0;
          // Chain straight into the next frame when more bytes are queued.
          if (have_byte) begin
            state_d = StStart;
            shift_d = fifo_rdata;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Registered-output next values and the FIFO pop strobe.
  always_comb begin
    tx_d   = tx_q;
    done_d = 1'b0;
    pop    = 1'b0;
    busy_d = (state_d != StIdle);
    case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (have_byte) begin
          pop  = 1'b1;
          tx_d = 1'b0;
        end
      end
      StStart: begin
        if (baud_end) tx_d = shift_q[0];
      end
      StData: begin
        if (baud_end) tx_d = (bit_q == 3'd7) ? 1'b1 : shift_q[1];
      end
      StStop: begin
        // Registered, so raise it one cycle early to cover the final stop cycle.
        done_d = (baud_q == BaudPreLast);
        if (baud_end) begin
          pop  = have_byte;
          tx_d = ~have_byte;
        end
      end
      default: tx_d = 1'b1;
    endcase
  end

  assign TX       = tx_q;
  assign dbg_done = done_q;
  assign tx_busy  = busy_q;

endmodule

// File: tb/tb_dbg_uart_tx.sv
// Directed self-checking bench for dbg_uart_tx with BAUD_DIV=4, FIFO_DEPTH=8.
module tb_dbg_uart_tx;

  logic       clk;
  logic       rst;
  logic [7:0] dbg_data;
  logic       dbg_tx;
  logic       clr_ovf;
  logic       TX;
  logic       dbg_done;
  logic       tx_busy;
  logic       full;
  logic       empty;
  logic       ovf;

  int n_total = 0;
  int n_bad   = 0;

  logic [7:0] pbuf [3];
  int         done_seen;
  int         tx_low;

  dbg_uart_tx #(
    .BAUD_DIV  (4),
    .FIFO_DEPTH(8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .dbg_data(dbg_data),
    .dbg_tx  (dbg_tx),
    .clr_ovf (clr_ovf),
    .TX      (TX),
    .dbg_done(dbg_done),
    .tx_busy (tx_busy),
    .full    (full),
    .empty   (empty),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Caller sits just after the edge preceding the frame's first (start-bit) edge.
  task automatic check_frame(input logic [7:0] b, input string tag);
    int   slot;
    logic e;
    for (int k = 0; k < 40; k++) begin
      tick();
      slot = k / 4;
      if (slot == 0)      e = 1'b0;
      else if (slot == 9) e = 1'b1;
      else                e = b[slot-1];
      check_eq($sformatf("%s tx k=%0d", tag, k), TX, e);
      check_eq($sformatf("%s done k=%0d", tag, k), dbg_done, (k == 39));
      check_eq($sformatf("%s busy k=%0d", tag, k), tx_busy, 1'b1);
    end
  endtask

  // Count done pulses and low TX samples over n idle cycles.
  task automatic watch_idle(input int n);
    done_seen = 0;
    tx_low    = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (dbg_done) done_seen++;
      if (!TX) tx_low++;
    end
  endtask

  initial begin
    rst      = 1'b1;
    dbg_tx   = 1'b0;
    dbg_data = 8'h00;
    clr_ovf  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check_eq("rst tx", TX, 1'b1);
    check_eq("rst done", dbg_done, 1'b0);
    check_eq("rst busy", tx_busy, 1'b0);
    check_eq("rst full", full, 1'b0);
    check_eq("rst empty", empty, 1'b1);
    check_eq("rst ovf", ovf, 1'b0);

    // Idle
    watch_idle(50);
    check_eq("idle done pulses", done_seen, 0);
    check_eq("idle tx low", tx_low, 0);
    check_eq("idle empty", empty, 1'b1);
    check_eq("idle busy", tx_busy, 1'b0);

    // Single byte 0xA5
    dbg_data = 8'hA5;
    dbg_tx   = 1'b1;
    tick();
    dbg_tx = 1'b0;
    check_eq("a5 empty after push", empty, 1'b0);
    check_eq("a5 busy after push", tx_busy, 1'b0);
    check_eq("a5 tx after push", TX, 1'b1);
    check_frame(8'hA5, "a5");
    tick();
    check_eq("a5 busy end", tx_busy, 1'b0);
    check_eq("a5 tx end", TX, 1'b1);
    check_eq("a5 empty end", empty, 1'b1);
    check_eq("a5 done end", dbg_done, 1'b0);

    // Three back-to-back bytes
    pbuf[0] = 8'h00;
    pbuf[1] = 8'hFF;
    pbuf[2] = 8'h3C;
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          dbg_data = pbuf[i];
          dbg_tx   = 1'b1;
          tick();
        end
        dbg_tx = 1'b0;
      end
      begin
        tick();
        for (int j = 0; j < 3; j++) check_frame(pbuf[j], $sformatf("burst%0d", j));
      end
    join
    check_eq("burst empty", empty, 1'b1);
    tick();
    check_eq("burst busy end", tx_busy, 1'b0);
    check_eq("burst tx end", TX, 1'b1);

    // Ten bytes: fill to full, tenth dropped
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          dbg_data = 8'(16 + i);
          dbg_tx   = 1'b1;
          tick();
          if (i == 7) check_eq("fill full at 7", full, 1'b0);
          if (i == 8) begin
            check_eq("fill full at 8", full, 1'b1);
            check_eq("fill ovf at 8", ovf, 1'b0);
          end
          if (i == 9) begin
            check_eq("fill full at 9", full, 1'b1);
            check_eq("fill ovf at 9", ovf, 1'b1);
          end
        end
        dbg_tx = 1'b0;
      end
      begin
        tick();
        for (int j = 0; j < 9; j++) check_frame(8'(16 + j), $sformatf("fill%0d", j));
      end
    join
    tick();
    check_eq("fill busy end", tx_busy, 1'b0);
    check_eq("fill empty end", empty, 1'b1);
    check_eq("fill ovf sticky", ovf, 1'b1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check_eq("fill ovf cleared", ovf, 1'b0);

    // Reset mid-frame with two bytes queued
    pbuf[0] = 8'h5B;
    pbuf[1] = 8'h11;
    pbuf[2] = 8'h22;
    for (int i = 0; i < 3; i++) begin
      dbg_data = pbuf[i];
      dbg_tx   = 1'b1;
      tick();
    end
    dbg_tx = 1'b0;
    repeat (11) tick();
    check_eq("abort tx bit2", TX, 1'b0);
    check_eq("abort busy before", tx_busy, 1'b1);
    check_eq("abort empty before", empty, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("abort tx", TX, 1'b1);
    check_eq("abort busy", tx_busy, 1'b0);
    check_eq("abort empty", empty, 1'b1);
    check_eq("abort full", full, 1'b0);
    check_eq("abort done", dbg_done, 1'b0);
    watch_idle(60);
    check_eq("abort done pulses", done_seen, 0);
    check_eq("abort tx low", tx_low, 0);

    // Same-edge clr_ovf and dropped push: set wins
    for (int i = 0; i < 10; i++) begin
      dbg_data = 8'(32 + i);
      dbg_tx   = 1'b1;
      clr_ovf  = (i == 9);
      tick();
    end
    dbg_tx  = 1'b0;
    clr_ovf = 1'b0;
    check_eq("race full", full, 1'b1);
    check_eq("race ovf set wins", ovf, 1'b1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check_eq("race ovf cleared", ovf, 1'b0);
    check_eq("race full held", full, 1'b1);

    rst = 1'b1;
    tick();
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
